// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - game inputs (positions, controls) and score/status outputs of score_keeper
interface score_keeper_if #(
  parameter int SCORE_W = 8,
  parameter int COORD_W = 10
);
  logic               new_game;
  logic [SCORE_W-1:0] max_score;
  logic [COORD_W-1:0] xball;
  logic [COORD_W-1:0] yball;
  logic [COORD_W-1:0] bar_x;
  logic [COORD_W-1:0] bar_len;
  logic [COORD_W-1:0] radius;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives;
  logic [1:0]         state;
  logic               caught;
  logic               missed;
  logic               ball_reset;
  logic               win;
  logic               game_over;

  modport master (
    output new_game, max_score, xball, yball, bar_x, bar_len, radius,
    input  score, lives, state, caught, missed, ball_reset, win, game_over
  );

  modport slave (
    input  new_game, max_score, xball, yball, bar_x, bar_len, radius,
    output score, lives, state, caught, missed, ball_reset, win, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - catch/miss detection, saturating score, lives and game FSM; optional STREAK_BONUS_EN
module score_keeper #(
  parameter int SCORE_W    = 8,
  parameter int COORD_W    = 10,
  parameter int LIVES      = 3,
  parameter int FLOOR_Y    = 455,
  parameter int STREAK_LEN = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_WIN  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
  localparam logic [COORD_W-1:0] FLOOR      = COORD_W'(FLOOR_Y);
  localparam logic [SCORE_W:0]   SCORE_TOP  = {1'b0, {SCORE_W{1'b1}}};

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;
  logic               zone, zone_q, zone_d;
  logic               event_w;
  logic               hit;
  logic               caught_q, caught_d;
  logic               missed_q, missed_d;
  logic [1:0]         inc;

`ifdef STREAK_BONUS_EN
  localparam int STREAK_W = $clog2(STREAK_LEN + 1);
  logic [STREAK_W-1:0] streak_q, streak_d, streak_inc;
  assign streak_inc = streak_q + 1'b1;
`endif

  // Geometry carried one bit wider so xball+radius and bar_x+bar_len cannot wrap
  logic [COORD_W:0] x_ext, r_ext, left, right, bar_l, bar_r;
  assign x_ext = {1'b0, bus.xball};
  assign r_ext = {1'b0, bus.radius};
  assign bar_l = {1'b0, bus.bar_x};
  assign bar_r = bar_l + {1'b0, bus.bar_len};
  assign left  = (x_ext < r_ext) ? '0 : (x_ext - r_ext);
  assign right = x_ext + r_ext;
  assign hit   = (left >= bar_l) && (right <= bar_r);

  // One event per descent: only the cycle the ball first enters the catch zone
  assign zone    = (bus.yball >= FLOOR);
  assign event_w = zone && !zone_q;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s, input logic [1:0] d);
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + (SCORE_W+1)'(d);
    return (sum > SCORE_TOP) ? SCORE_TOP[SCORE_W-1:0] : sum[SCORE_W-1:0];
  endfunction

  // Next-state and next-value logic; new_game overrides every state
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    lives_d  = lives_q;
    zone_d   = zone;
    caught_d = 1'b0;
    missed_d = 1'b0;
    inc      = 2'd1;
`ifdef STREAK_BONUS_EN
    streak_d = streak_q;
`endif
    if (bus.new_game) begin
      state_d = S_PLAY;
      score_d = '0;
      lives_d = LIVES_INIT;
      zone_d  = 1'b1;
`ifdef STREAK_BONUS_EN
      streak_d = '0;
`endif
    end else begin
      case (state_q)
        S_PLAY: begin
          if (score_q >= bus.max_score) begin
            state_d = S_WIN;
          end else if (event_w) begin
            if (hit) begin
              caught_d = 1'b1;
`ifdef STREAK_BONUS_EN
              if (streak_inc == STREAK_W'(STREAK_LEN)) begin
                inc      = 2'd2;
                streak_d = '0;
              end else begin
                streak_d = streak_inc;
              end
`endif
              score_d = sat_add(score_q, inc);
            end else begin
              missed_d = 1'b1;
              lives_d  = lives_q - 4'd1;
`ifdef STREAK_BONUS_EN
              streak_d = '0;
`endif
              if (lives_q == 4'd1) begin
                state_d = S_OVER;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State, score, lives, zone history and event pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      lives_q  <= LIVES_INIT;
      zone_q   <= 1'b1;
      caught_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      zone_q   <= zone_d;
      caught_q <= caught_d;
      missed_q <= missed_d;
    end
  end

`ifdef STREAK_BONUS_EN
  // Consecutive-catch counter for the bonus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.state      = state_q;
  assign bus.caught     = caught_q;
  assign bus.missed     = missed_q;
  assign bus.ball_reset = missed_q;
  assign bus.win        = (state_q == S_WIN);
  assign bus.game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed vector bench for score_keeper
module tb_score_keeper;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  score_keeper_if #(.SCORE_W(8), .COORD_W(10)) bus ();

  score_keeper #(
    .SCORE_W(8), .COORD_W(10), .LIVES(3), .FLOOR_Y(455), .STREAK_LEN(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] xball;
    logic [9:0] radius;
    logic [9:0] bar_x;
    logic [9:0] bar_len;
    int         exp_caught;
    int         exp_missed;
    int         exp_score;
    int         exp_lives;
    int         exp_state;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic watch(input int cycles, output int nc, output int nm, output int nbr);
    nc = 0; nm = 0; nbr = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.caught) nc++;
      if (bus.missed) nm++;
      if (bus.ball_reset) nbr++;
    end
  endtask

  task automatic descent(input logic [9:0] x, input logic [9:0] r, input logic [9:0] bx,
                         input logic [9:0] bl, output int nc, output int nm, output int nbr);
    bus.xball   = x;
    bus.radius  = r;
    bus.bar_x   = bx;
    bus.bar_len = bl;
    bus.yball   = 10'd450;
    repeat (2) @(negedge clk);
    bus.yball = 10'd460;
    watch(20, nc, nm, nbr);
    bus.yball = 10'd450;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_new_game();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
  endtask

  task automatic check_status(input string tag, input int s, input int l, input int st);
    chk({tag, " score"}, int'(bus.score), s);
    chk({tag, " lives"}, int'(bus.lives), l);
    chk({tag, " state"}, int'(bus.state), st);
  endtask

  initial begin
    int nc, nm, nbr;
    errors = 0;
    checks = 0;

    vecs[0] = '{10'd100, 10'd8, 10'd80,  10'd60, 1, 0, 1, 3, 1};
    vecs[1] = '{10'd100, 10'd8, 10'd200, 10'd60, 0, 1, 1, 2, 1};
    vecs[2] = '{10'd100, 10'd8, 10'd92,  10'd16, 1, 0, 2, 2, 1};
    vecs[3] = '{10'd3,   10'd8, 10'd0,   10'd11, 1, 0, 3, 2, 1};
    vecs[4] = '{10'd100, 10'd8, 10'd93,  10'd16, 0, 1, 3, 1, 1};

    rst_n         = 1'b0;
    bus.new_game  = 1'b0;
    bus.max_score = 8'd200;
    bus.xball     = 10'd100;
    bus.yball     = 10'd450;
    bus.bar_x     = 10'd80;
    bus.bar_len   = 10'd60;
    bus.radius    = 10'd8;
    repeat (3) @(negedge clk);
    check_status("reset", 0, 3, 0);
    chk("reset caught", int'(bus.caught), 0);
    chk("reset missed", int'(bus.missed), 0);
    rst_n = 1'b1;
    @(negedge clk);

    descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    chk("idle caught", nc, 0);
    chk("idle score", int'(bus.score), 0);

    pulse_new_game();
    chk("start state", int'(bus.state), 1);

    for (int i = 0; i < 5; i++) begin
      descent(vecs[i].xball, vecs[i].radius, vecs[i].bar_x, vecs[i].bar_len, nc, nm, nbr);
      chk($sformatf("vec%0d caught", i), nc, vecs[i].exp_caught);
      chk($sformatf("vec%0d missed", i), nm, vecs[i].exp_missed);
      chk($sformatf("vec%0d ball_reset", i), nbr, vecs[i].exp_missed);
      check_status($sformatf("vec%0d", i), vecs[i].exp_score, vecs[i].exp_lives, vecs[i].exp_state);
    end

    descent(10'd100, 10'd8, 10'd200, 10'd60, nc, nm, nbr);
    chk("last miss pulses", nm, 1);
    check_status("over", 3, 0, 3);
    chk("over game_over", int'(bus.game_over), 1);
    descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    chk("over ignores caught", nc, 0);
    check_status("over frozen", 3, 0, 3);

    pulse_new_game();
    check_status("restart", 0, 3, 1);

    bus.max_score = 8'd3;
    repeat (3) descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    check_status("win", 3, 3, 2);
    chk("win flag", int'(bus.win), 1);
    descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    chk("win ignores caught", nc, 0);
    chk("win score held", int'(bus.score), 3);

    bus.max_score = 8'd200;
    bus.yball     = 10'd470;
    pulse_new_game();
    watch(10, nc, nm, nbr);
    chk("in-zone start caught", nc, 0);
    chk("in-zone start missed", nm, 0);
    descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    chk("reentry caught", nc, 1);
    chk("reentry score", int'(bus.score), 1);

    bus.max_score = 8'd0;
    pulse_new_game();
    chk("max0 first cycle", int'(bus.state), 1);
    @(negedge clk);
    chk("max0 win", int'(bus.state), 2);

    bus.max_score = 8'd200;
    pulse_new_game();
    descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    chk("pre-reset score", int'(bus.score), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_status("async reset", 0, 3, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef STREAK_BONUS_EN
    pulse_new_game();
    repeat (5) descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    chk("streak five", int'(bus.score), 6);
    descent(10'd100, 10'd8, 10'd200, 10'd60, nc, nm, nbr);
    descent(10'd100, 10'd8, 10'd80, 10'd60, nc, nm, nbr);
    chk("streak restart", int'(bus.score), 7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
